// File: rtl/vrf_port_arbiter.sv
// -----------------------------------------------------------------------------
// vrf_port_arbiter
//
// Shares a single-port vector register file RAM between two requesters:
// port 0 is the vector execute sequencer, port 1 the vector load/store unit.
// Arbitration is round-robin with an optional per-beat lock, so one port can
// finish a multi-register group (LMUL > 1) without the other port's beats
// being interleaved. Read data is returned to whichever port issued the read.
// A watchdog force-releases a lock whose owner has stopped requesting.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   req_i[1:0]              per-port access request
//   we_i[1:0]               per-port write enable (1 = write, 0 = read)
//   lock_i[1:0]             per-port lock: keep ownership after this beat
//   addr0_i, addr1_i        per-port register address
//   wdata0_i, wdata1_i      per-port write data
//   gnt_o[1:0]              combinational grant, one-hot or zero
//   rvalid_o[1:0]           registered read-data valid, one-hot per port
//   rdata_o                 shared read data, qualified by rvalid_o
//   lock_err_o              one-cycle pulse on watchdog lock release
//   ram_req_o, ram_we_o     RAM strobe and write enable
//   ram_addr_o, ram_wdata_o RAM address and write data
//   ram_rdata_i             RAM read data, valid the cycle after a read
//
// Registers
//   lock_q     | a port currently holds exclusive ownership
//   owner_q    | which port holds the lock (meaningful only when lock_q)
//   prio_q     | port that wins the next unlocked tie
//   idle_cnt_q | consecutive cycles the lock owner has not requested
//   rd_pend_q  | one-hot port whose read was granted last cycle
//   lock_err_q | watchdog released a lock at the last edge
// -----------------------------------------------------------------------------
module vrf_port_arbiter #(
    parameter int unsigned VLEN        = 128,
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned LockTimeout = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           req_i,
    input  logic [1:0]           we_i,
    input  logic [1:0]           lock_i,
    input  logic [AddrWidth-1:0] addr0_i,
    input  logic [AddrWidth-1:0] addr1_i,
    input  logic [VLEN-1:0]      wdata0_i,
    input  logic [VLEN-1:0]      wdata1_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           rvalid_o,
    output logic [VLEN-1:0]      rdata_o,
    output logic                 lock_err_o,
    output logic                 ram_req_o,
    output logic                 ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [VLEN-1:0]      ram_wdata_o,
    input  logic [VLEN-1:0]      ram_rdata_i
);

    localparam int unsigned     CntW    = $clog2(LockTimeout + 1);
    localparam logic [CntW-1:0] IdleMax = CntW'(LockTimeout - 1);

    logic            lock_q,     lock_d;
    logic            owner_q,    owner_d;
    logic            prio_q,     prio_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]      rd_pend_q,  rd_pend_d;
    logic            lock_err_q, lock_err_d;

    logic [1:0] gnt;
    logic       gnt_any;
    logic       gnt_sel;
    logic       sel_we;
    logic       sel_lock;

    // Grant decode. Reset forces every grant low so no RAM access can be
    // issued while the arbiter state is being cleared.
    always_comb begin
        gnt = 2'b00;
        if (!rst_i) begin
            if (lock_q) begin
                gnt[owner_q] = req_i[owner_q];
            end else begin
                case (req_i)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                    default: gnt = 2'b00;
                endcase
            end
        end
    end

    assign gnt_any  = |gnt;
    assign gnt_sel  = gnt[1];
    assign sel_we   = gnt_sel ? we_i[1]   : we_i[0];
    assign sel_lock = gnt_sel ? lock_i[1] : lock_i[0];

    assign gnt_o       = gnt;
    assign ram_req_o   = gnt_any;
    assign ram_we_o    = gnt_any & sel_we;
    assign ram_addr_o  = gnt_sel ? addr1_i  : addr0_i;
    assign ram_wdata_o = gnt_sel ? wdata1_i : wdata0_i;

    // RAM read data is already aligned with rd_pend_q, so it is passed
    // straight through rather than re-registered.
    assign rdata_o    = ram_rdata_i;
    assign rvalid_o   = rd_pend_q;
    assign lock_err_o = lock_err_q;

    always_comb begin
        lock_d     = lock_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        idle_cnt_d = idle_cnt_q;
        rd_pend_d  = 2'b00;
        lock_err_d = 1'b0;

        if (gnt_any) begin
            if (!sel_we) begin
                rd_pend_d = gnt;
            end
            // A granted beat always restarts the idle count: either the owner
            // just used its lock, or the lock is being taken fresh.
            idle_cnt_d = '0;
            if (sel_lock) begin
                lock_d  = 1'b1;
                owner_d = gnt_sel;
            end else begin
                lock_d = 1'b0;
                prio_d = ~gnt_sel;
            end
        end else if (lock_q) begin
            if (req_i[owner_q]) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == IdleMax) begin
                // Owner abandoned the lock: release it and hand the next tie
                // to the other port so the stalled requester goes first.
                lock_d     = 1'b0;
                idle_cnt_d = '0;
                lock_err_d = 1'b1;
                prio_d     = ~owner_q;
            end else begin
                idle_cnt_d = idle_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            idle_cnt_q <= '0;
            rd_pend_q  <= 2'b00;
            lock_err_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            idle_cnt_q <= idle_cnt_d;
            rd_pend_q  <= rd_pend_d;
            lock_err_q <= lock_err_d;
        end
    end

endmodule

// File: tb/tb_vrf_port_arbiter.sv
module tb_vrf_port_arbiter;

    localparam int VLEN = 128;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req, we, lock;
    logic [AW-1:0]   addr0, addr1;
    logic [VLEN-1:0] wdata0, wdata1;
    logic [1:0]      gnt, rvalid;
    logic [VLEN-1:0] rdata;
    logic            lock_err;
    logic            ram_req, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [VLEN-1:0] ram_wdata;
    logic [VLEN-1:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vrf_port_arbiter #(.VLEN(VLEN), .AddrWidth(AW), .LockTimeout(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .lock_err_o(lock_err),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // Behavioural single-port RAM, one-cycle read latency.
    logic [VLEN-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_req && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_req && !ram_we) ram_rdata <= mem[ram_addr];
    end

    function automatic logic [VLEN-1:0] word(input int a);
        logic [31:0] w;
        w = 32'h1000_0000 + 32'(a);
        return {4{w}};
    endfunction

    task automatic idle_inputs();
        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11; we = 2'b11;
        #2;
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL reset_ram_req got=%b exp=0", ram_req); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
        n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL reset_lock_err got=%b exp=0", lock_err); end
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        @(posedge clk); #1;
        req = 2'b01; we = 2'b00; addr0 = 5'd3;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got=%b exp=01", gnt); end
        n_checks++; if (ram_addr !== 5'd3) begin n_fail++; $display("FAIL rd_addr got=%0d exp=3", ram_addr); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rd_we got=%b exp=0", ram_we); end
        n_checks++; if (ram_req !== 1'b1) begin n_fail++; $display("FAIL rd_req got=%b exp=1", ram_req); end
        @(posedge clk); #1;
        idle_inputs();
        #2;
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=01", rvalid); end
        n_checks++; if (rdata !== word(3)) begin n_fail++; $display("FAIL rd_rdata got=%h exp=%h", rdata, word(3)); end
        @(posedge clk); #1;
        #2;
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rd_rvalid_clear got=%b exp=00", rvalid); end
    endtask

    task automatic test_alternation();
        logic [1:0]      eg;
        logic [AW-1:0]   ea;
        logic [VLEN-1:0] ed;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            req = 2'b11; we = 2'b11; lock = 2'b00;
            addr0 = 5'd10; addr1 = 5'd20;
            wdata0 = {4{32'hAAAA_0000}}; wdata1 = {4{32'h5555_1111}};
            #2;
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            ea = (i % 2 == 0) ? 5'd10 : 5'd20;
            ed = (i % 2 == 0) ? {4{32'hAAAA_0000}} : {4{32'h5555_1111}};
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", i, gnt, eg); end
            n_checks++; if (ram_addr !== ea) begin n_fail++; $display("FAIL alt_addr[%0d] got=%0d exp=%0d", i, ram_addr, ea); end
            n_checks++; if (ram_wdata !== ed) begin n_fail++; $display("FAIL alt_wdata[%0d] got=%h exp=%h", i, ram_wdata, ed); end
            n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL alt_we[%0d] got=%b exp=1", i, ram_we); end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_lock();
        logic [1:0]      ev;
        logic [VLEN-1:0] ed;
        do_reset();
        // Port 0 beat first so that port 1 holds the next tie.
        @(posedge clk); #1;
        req = 2'b01; we = 2'b00; addr0 = 5'd1; lock = 2'b00;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lock_pre_gnt got=%b exp=01", gnt); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            req = 2'b11; we = 2'b00; addr0 = 5'd1; addr1 = 5'(4 + i);
            lock = (i < 3) ? 2'b10 : 2'b00;
            #2;
            ev = (i == 0) ? 2'b01 : 2'b10;
            ed = (i == 0) ? word(1) : word(4 + i - 1);
            n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lock_gnt[%0d] got=%b exp=10", i, gnt); end
            n_checks++; if (ram_addr !== 5'(4 + i)) begin n_fail++; $display("FAIL lock_addr[%0d] got=%0d exp=%0d", i, ram_addr, 4 + i); end
            n_checks++; if (rvalid !== ev) begin n_fail++; $display("FAIL lock_rvalid[%0d] got=%b exp=%b", i, rvalid, ev); end
            n_checks++; if (rdata !== ed) begin n_fail++; $display("FAIL lock_rdata[%0d] got=%h exp=%h", i, rdata, ed); end
        end
        @(posedge clk); #1;
        req = 2'b01; lock = 2'b00; addr0 = 5'd1;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lock_after_gnt got=%b exp=01", gnt); end
        n_checks++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL lock_last_rvalid got=%b exp=10", rvalid); end
        n_checks++; if (rdata !== word(7)) begin n_fail++; $display("FAIL lock_last_rdata got=%h exp=%h", rdata, word(7)); end
        @(posedge clk); #1;
        idle_inputs();
        #2;
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL lock_p0_rvalid got=%b exp=01", rvalid); end
        n_checks++; if (rdata !== word(1)) begin n_fail++; $display("FAIL lock_p0_rdata got=%h exp=%h", rdata, word(1)); end
    endtask

    task automatic test_watchdog();
        do_reset();
        @(posedge clk); #1;
        req = 2'b01; we = 2'b00; addr0 = 5'd2; lock = 2'b01;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL wd_lock_gnt got=%b exp=01", gnt); end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            req = 2'b10; we = 2'b10; addr1 = 5'd9; lock = 2'b00;
            wdata1 = {4{32'hDEAD_BEEF}};
            #2;
            n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wd_stall_gnt[%0d] got=%b exp=00", k, gnt); end
            n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL wd_early_err[%0d] got=%b exp=0", k, lock_err); end
            if (k == 1) begin
                n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL wd_rvalid got=%b exp=01", rvalid); end
            end
        end
        @(posedge clk); #1;
        #2;
        n_checks++; if (lock_err !== 1'b1) begin n_fail++; $display("FAIL wd_err_pulse got=%b exp=1", lock_err); end
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL wd_release_gnt got=%b exp=10", gnt); end
        @(posedge clk); #1;
        idle_inputs();
        #2;
        n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL wd_err_width got=%b exp=0", lock_err); end
    endtask

    task automatic test_watchdog_race();
        do_reset();
        @(posedge clk); #1;
        req = 2'b01; we = 2'b00; addr0 = 5'd2; lock = 2'b01;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL race_lock_gnt got=%b exp=01", gnt); end
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            req = 2'b10; we = 2'b00; addr1 = 5'd9; lock = 2'b00;
            #2;
            n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL race_stall_gnt[%0d] got=%b exp=00", k, gnt); end
        end
        // Owner returns on the very cycle the count reaches its limit.
        @(posedge clk); #1;
        req = 2'b11; lock = 2'b01; addr0 = 5'd2;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL race_owner_gnt got=%b exp=01", gnt); end
        @(posedge clk); #1;
        req = 2'b10; lock = 2'b00;
        #2;
        n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL race_no_err got=%b exp=0", lock_err); end
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL race_still_locked got=%b exp=00", gnt); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(posedge clk); #1;
        req = 2'b10; we = 2'b00; addr1 = 5'd6; lock = 2'b10;
        #2;
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rst_rd_gnt got=%b exp=10", gnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        #2;
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid_drop got=%b exp=00", rvalid); end
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid_after got=%b exp=00", rvalid); end
        @(posedge clk); #1;
        req = 2'b11; we = 2'b00; lock = 2'b00;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_tie_gnt got=%b exp=01", gnt); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        @(posedge clk); #1;
        req = 2'b10; we = 2'b10; addr1 = 5'd7; wdata1 = {16{8'hA5}}; lock = 2'b00;
        #2;
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL wr_gnt got=%b exp=10", gnt); end
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_we got=%b exp=1", ram_we); end
        @(posedge clk); #1;
        req = 2'b01; we = 2'b00; addr0 = 5'd7;
        #2;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL wr_rd_gnt got=%b exp=01", gnt); end
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rvalid got=%b exp=00", rvalid); end
        @(posedge clk); #1;
        idle_inputs();
        #2;
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL wr_rd_rvalid got=%b exp=01", rvalid); end
        n_checks++; if (rdata !== {16{8'hA5}}) begin n_fail++; $display("FAIL wr_rd_rdata got=%h exp=%h", rdata, {16{8'hA5}}); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = word(i);
        ram_rdata = '0;
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_single_read();
        test_alternation();
        test_lock();
        test_watchdog();
        test_watchdog_race();
        test_reset_mid_read();
        test_write_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vrf_port_arbiter.md
# vrf_port_arbiter

Arbiter that shares the single-port vector register file RAM (VLEN-wide words, one access per cycle) between two requesters. Port 0 is the vector execute sequencer and port 1 is the vector load/store unit. Grants are round-robin, with an optional lock so one port can complete a multi-register group (LMUL > 1) without interleaving. Read responses are routed back to the port that issued them, and a watchdog releases a lock its owner has stopped using.

## Interface
- VLEN, 128: RAM word width in bits.
- AddrWidth, 5: RAM address width (2**AddrWidth vector registers).
- LockTimeout, 16: consecutive idle-owner cycles before a held lock is force-released (≥ 1).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  2  per-port access request; bit p belongs to port p.
- we_i  in  2  per-port write enable (1 = write, 0 = read).
- lock_i  in  2  per-port lock: hold ownership after this beat.
- addr0_i, addr1_i  in  AddrWidth  per-port register address.
- wdata0_i, wdata1_i  in  VLEN  per-port write data.
- gnt_o  out  2  per-port grant, combinational, one-hot or zero.
- rvalid_o  out  2  per-port read-data valid, registered.
- rdata_o  out  VLEN  read data shared by both ports; qualified by rvalid_o.
- lock_err_o  out  1  one-cycle pulse when the watchdog force-releases a lock.
- ram_req_o  out  1  RAM access strobe.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  AddrWidth  RAM address.
- ram_wdata_o  out  VLEN  RAM write data.
- ram_rdata_i  in  VLEN  RAM read data, valid the cycle after a read strobe.

## Operation
- State: lock_q (1b), owner_q (1b), prio_q (1b), idle_cnt_q (width clog2(LockTimeout+1)), rd_pend_q (2b, one-hot port of the read issued last cycle).
- Grant when unlocked:
  - only port p requests → grant p;
  - both request → grant prio_q.
- Grant when locked: grant owner_q only if req_i[owner_q]; the other port gets no grant (stalls).
- A beat completes when gnt_o[p]=1. That cycle:
  - ram_req_o=1;
  - ram_we_o, ram_addr_o and ram_wdata_o are muxed from port p;
  - when no port is granted, ram_req_o=0 and ram_we_o=0.
- Lock update on a granted beat of port p:
  - lock_i[p]=1 → lock_q=1, owner_q=p;
  - lock_i[p]=0 → lock_q=0.
- Priority update: prio_q=~p after a granted beat with lock_i[p]=0. prio_q is unchanged while a lock is held, so after the lock is released the other port wins the next tie.
- Watchdog, active only while lock_q=1:
  - idle_cnt_q increments each cycle req_i[owner_q]=0 and clears on any owner request;
  - when idle_cnt_q reaches LockTimeout-1 and the owner is still idle, the next edge sets lock_q=0 and idle_cnt_q=0, and lock_err_o=1 for exactly that following cycle;
  - prio_q is set to ~owner_q.
- Read return:
  - a granted read on port p sets rd_pend_q=onehot(p) at the next edge, otherwise rd_pend_q=0;
  - rvalid_o=rd_pend_q;
  - rdata_o=ram_rdata_i, passed through combinationally (not re-registered).
- Write then read of the same address in consecutive cycles is ordered by the RAM. The arbiter does no forwarding.

## Timing
- Reset (rst_i=1, asynchronous):
  - lock_q=0, owner_q=0, prio_q=0, idle_cnt_q=0, rd_pend_q=0;
  - gnt_o=0, ram_req_o=0 and ram_we_o=0 forced while rst_i is high;
  - rvalid_o=0, lock_err_o=0.
- Reset mid-lock or mid-read: the lock is dropped and the pending rvalid is discarded. There is no response after reset deasserts.
- Grant latency: 0 cycles (gnt_o in the same cycle as req_i when arbitration allows).
- Read latency: rvalid_o is high exactly 1 cycle after the granted read cycle.
- Back-to-back beats by one port: 1 per cycle. Sustained contention, unlocked: strict alternation 0,1,0,1…
- Requesters hold req/we/addr/wdata/lock stable until granted. A request can be withdrawn before grant; there is no error for this.
- Simultaneous events:
  - owner releases the lock and the other port requests in the same cycle: the owner is granted this cycle, the other port next cycle;
  - watchdog expiry and an owner request on the same edge: the request wins and idle_cnt_q clears.

## Test plan
- Reset, then port 0 read addr 3 alone → gnt_o=01, ram_addr_o=3, ram_we_o=0; next cycle rvalid_o=01 and rdata_o equals the RAM word at 3.
- Both ports request continuous writes for 6 cycles, lock=0 → grants 0,1,0,1,0,1; each ram_addr_o/ram_wdata_o matches the granted port.
- Port 1 does 4 locked reads (lock=1,1,1,0) while port 0 requests continuously → gnt_o=10 for 4 cycles, then 01; rvalid_o=10 on cycles 2–5.
- Port 0 locks, drops req with LockTimeout=16, port 1 requesting → gnt_o[1]=0 for 16 cycles; lock_err_o pulses on cycle 17 and port 1 is granted that cycle.
- rst_i asserted the cycle after a granted read → rvalid_o stays 0; after release, lock_q=0 and prio_q=0 (a tie grants port 0).
- Write addr 7 = 0xA5… by port 1, then read addr 7 by port 0 → port 0 rvalid returns 0xA5….
